// File: rtl/gmii_tx_sync_scheduler.sv
// rtl/gmii_tx_sync_scheduler.sv - GMII TX arbiter for host frames and periodic sync frames (option: SYNC_MISS_CNT_EN)
module gmii_tx_sync_scheduler #(
   parameter int SYNC_PERIOD  = 125000,
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_CYCLES   = 12,
   parameter int PAD_BYTES    = 44
) (
   input  logic        clk_125m,
   input  logic        rst,
   input  logic        sync_en,
   input  logic [15:0] local_time,
   input  logic        host_valid,
   input  logic [7:0]  host_data,
   input  logic        host_last,
   output logic        host_ready,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic        sync_sent,
   output logic [31:0] cnt_sync,
   output logic [15:0] sync_miss
);

   localparam int BODY_LEN = 16 + PAD_BYTES;
   localparam int PER_W    = $clog2(SYNC_PERIOD + 1);
   localparam int PRE_W    = $clog2(PREAMBLE_LEN + 1);
   localparam int IFG_W    = $clog2(IFG_CYCLES + 1);
   localparam int IDX_W    = $clog2(BODY_LEN + 1);

   localparam logic [PER_W-1:0] PER_LAST = PER_W'(SYNC_PERIOD - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
   localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BODY_LEN - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PREAMBLE = 3'd1;
   localparam logic [2:0] S_SFD      = 3'd2;
   localparam logic [2:0] S_HOST     = 3'd3;
   localparam logic [2:0] S_PTP      = 3'd4;
   localparam logic [2:0] S_IFG      = 3'd5;

   logic [2:0]       state;
   logic             src_ptp;
   logic [15:0]      t0;
   logic             sync_pending;
   logic [PER_W-1:0] per_cnt;
   logic [PRE_W-1:0] pre_cnt;
   logic [IFG_W-1:0] ifg_cnt;
   logic [IDX_W-1:0] idx;
   logic             tick;
   logic             take_sync;
   logic [7:0]       ptp_byte;

   assign tick       = sync_en && (per_cnt == PER_LAST);
   assign take_sync  = (state == S_IDLE) && sync_pending;
   assign host_ready = (state == S_HOST) && !rst;

   // period counter: runs only while enabled, wraps on the tick cycle
   always_ff @(posedge clk_125m) begin
      if (rst || !sync_en || tick)
         per_cnt <= '0;
      else
         per_cnt <= per_cnt + 1'b1;
   end

   // pending flag: a tick wins over the IDLE consumption on the same cycle
   always_ff @(posedge clk_125m) begin
      if (rst)
         sync_pending <= 1'b0;
      else if (tick)
         sync_pending <= 1'b1;
      else if (take_sync)
         sync_pending <= 1'b0;
   end

`ifdef SYNC_MISS_CNT_EN
   // count ticks lost because a sync was still waiting, saturating
   always_ff @(posedge clk_125m) begin
      if (rst)
         sync_miss <= '0;
      else if (tick && sync_pending && !take_sync && (sync_miss != 16'hFFFF))
         sync_miss <= sync_miss + 16'd1;
   end
`else
   assign sync_miss = 16'h0000;
`endif

   // sync body byte for the current index: dmac, type, reserved, t0, then zeros
   always_comb begin
      ptp_byte = 8'h00;
      if (idx < IDX_W'(6))
         ptp_byte = 8'(idx);
      else if (idx == IDX_W'(6))
         ptp_byte = 8'h01;
      else if (idx == IDX_W'(8))
         ptp_byte = t0[15:8];
      else if (idx == IDX_W'(9))
         ptp_byte = t0[7:0];
   end

   // frame sequencer; GMII outputs are registered one cycle behind the state
   always_ff @(posedge clk_125m) begin
      if (rst) begin
         state      <= S_IDLE;
         src_ptp    <= 1'b0;
         t0         <= '0;
         pre_cnt    <= '0;
         ifg_cnt    <= '0;
         idx        <= '0;
         gmii_txd   <= 8'h00;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         sync_sent  <= 1'b0;
         cnt_sync   <= '0;
      end else begin
         gmii_txd   <= 8'h00;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         sync_sent  <= 1'b0;
         case (state)
            S_IDLE: begin
               pre_cnt <= '0;
               if (sync_pending) begin
                  t0      <= local_time;
                  src_ptp <= 1'b1;
                  state   <= S_PREAMBLE;
               end else if (host_valid) begin
                  src_ptp <= 1'b0;
                  state   <= S_PREAMBLE;
               end
            end
            S_PREAMBLE: begin
               gmii_tx_en <= 1'b1;
               gmii_txd   <= 8'h55;
               if (pre_cnt == PRE_LAST)
                  state <= S_SFD;
               else
                  pre_cnt <= pre_cnt + 1'b1;
            end
            S_SFD: begin
               gmii_tx_en <= 1'b1;
               gmii_txd   <= 8'hD5;
               idx        <= '0;
               state      <= src_ptp ? S_PTP : S_HOST;
            end
            S_HOST: begin
               gmii_tx_en <= 1'b1;
               if (host_valid) begin
                  gmii_txd <= host_data;
                  if (host_last) begin
                     ifg_cnt <= '0;
                     state   <= S_IFG;
                  end
               end else begin
                  gmii_tx_er <= 1'b1;
               end
            end
            S_PTP: begin
               gmii_tx_en <= 1'b1;
               gmii_txd   <= ptp_byte;
               if (idx == IDX_LAST) begin
                  sync_sent <= 1'b1;
                  cnt_sync  <= cnt_sync + 32'd1;
                  ifg_cnt   <= '0;
                  state     <= S_IFG;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_IFG: begin
               if (ifg_cnt == IFG_LAST)
                  state <= S_IDLE;
               else
                  ifg_cnt <= ifg_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_sync_scheduler.sv
// tb/tb_gmii_tx_sync_scheduler.sv - self-checking bench for gmii_tx_sync_scheduler
module tb_gmii_tx_sync_scheduler;

   localparam int P    = 100;
   localparam int PRE  = 7;
   localparam int IFG  = 12;
   localparam int PAD  = 44;
   localparam int SLEN = PRE + 1 + 16 + PAD;
   localparam int LOGN = 16384;

   logic        clk_125m = 1'b0;
   logic        rst = 1'b1;
   logic        sync_en = 1'b0;
   logic [15:0] local_time = 16'h0000;
   logic        host_valid = 1'b0;
   logic [7:0]  host_data = 8'h00;
   logic        host_last = 1'b0;
   logic        host_ready;
   logic [7:0]  gmii_txd;
   logic        gmii_tx_en;
   logic        gmii_tx_er;
   logic        sync_sent;
   logic [31:0] cnt_sync;
   logic [15:0] sync_miss;

   gmii_tx_sync_scheduler #(
      .SYNC_PERIOD (P),
      .PREAMBLE_LEN(PRE),
      .IFG_CYCLES  (IFG),
      .PAD_BYTES   (PAD)
   ) dut (
      .clk_125m  (clk_125m),
      .rst       (rst),
      .sync_en   (sync_en),
      .local_time(local_time),
      .host_valid(host_valid),
      .host_data (host_data),
      .host_last (host_last),
      .host_ready(host_ready),
      .gmii_txd  (gmii_txd),
      .gmii_tx_en(gmii_tx_en),
      .gmii_tx_er(gmii_tx_er),
      .sync_sent (sync_sent),
      .cnt_sync  (cnt_sync),
      .sync_miss (sync_miss)
   );

   always #4 clk_125m = ~clk_125m;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   bit lt_run = 1'b0;

   logic        log_en [LOGN];
   logic        log_er [LOGN];
   logic        log_ss [LOGN];
   logic        log_rdy[LOGN];
   logic [7:0]  log_d  [LOGN];
   logic [15:0] log_lt [LOGN];

   logic [7:0] hb[$];
   int         hg[$];
   int         acc_cyc[$];
   logic [8:0] all_ex[$];

   always @(posedge clk_125m) cyc <= cyc + 1;

   // per-cycle record of everything on the line, taken mid-cycle
   always @(negedge clk_125m) begin
      #1;
      if (cyc < LOGN) begin
         log_en[cyc]  = gmii_tx_en;
         log_er[cyc]  = gmii_tx_er;
         log_ss[cyc]  = sync_sent;
         log_rdy[cyc] = host_ready;
         log_d[cyc]   = gmii_txd;
         log_lt[cyc]  = local_time;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_125m);
      if (lt_run) local_time = 16'(cyc * 7 + 4660);
   endtask

   task automatic make_frame(input int n, input int gap_pct);
      hb.delete();
      hg.delete();
      for (int i = 0; i < n; i++) begin
         hb.push_back(8'($urandom));
         hg.push_back(($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 3)) : 0);
      end
   endtask

   // expected line image of the current host frame: preamble, SFD, underruns, bytes
   task automatic build_exp(output int off, output int len);
      off = all_ex.size();
      for (int k = 0; k < PRE; k++) all_ex.push_back(9'h055);
      all_ex.push_back(9'h0D5);
      for (int i = 0; i < hb.size(); i++) begin
         for (int g = 0; g < hg[i]; g++) all_ex.push_back(9'h100);
         all_ex.push_back({1'b0, hb[i]});
      end
      len = all_ex.size() - off;
   endtask

   // host side driver: underruns only once the frame is being accepted
   task automatic send_host(input int max_acc, input int budget);
      int i = 0;
      int gl;
      int n;
      int spent = 0;
      n = hb.size();
      gl = hg[0];
      acc_cyc.delete();
      while (i < n && i < max_acc && spent < budget) begin
         if (host_ready === 1'b1 && gl > 0) begin
            host_valid = 1'b0;
            host_last  = 1'b0;
            gl--;
         end else begin
            host_valid = 1'b1;
            host_data  = hb[i];
            host_last  = (i == n - 1);
            if (host_ready === 1'b1) begin
               acc_cyc.push_back(cyc);
               i++;
               if (i < n) gl = hg[i];
            end
         end
         step();
         spent++;
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
      host_data  = 8'h00;
      chk("host_send_complete", i, (max_acc < n) ? max_acc : n);
   endtask

   function automatic int next_start(input int from, input int upto);
      for (int c = from; c < upto && c < LOGN; c++)
         if (log_en[c] === 1'b1 && (c == 0 || log_en[c-1] === 1'b0)) return c;
      return -1;
   endfunction

   function automatic int frame_end(input int s);
      int c = s;
      while (c < LOGN - 1 && log_en[c] === 1'b1) c++;
      return c - 1;
   endfunction

   function automatic int host_errs(input int s, input int off, input int n);
      int e = 0;
      if (s < 0 || s + n >= LOGN) return 999;
      for (int k = 0; k < n; k++)
         if (log_en[s+k] !== 1'b1 || {log_er[s+k], log_d[s+k]} !== all_ex[off+k]) e++;
      if (log_en[s+n] !== 1'b0) e++;
      return e;
   endfunction

   // a sync frame is fully determined by local_time on its IDLE decision cycle
   function automatic int sync_errs(input int s);
      int e = 0;
      int j;
      logic [15:0] t0;
      logic [7:0]  b;
      if (s < 2 || s + SLEN >= LOGN) return 999;
      t0 = log_lt[s-2];
      for (int k = 0; k < SLEN; k++) begin
         if (k < PRE) b = 8'h55;
         else if (k == PRE) b = 8'hD5;
         else begin
            j = k - PRE - 1;
            if (j < 6) b = 8'(j);
            else if (j == 6) b = 8'h01;
            else if (j == 8) b = t0[15:8];
            else if (j == 9) b = t0[7:0];
            else b = 8'h00;
         end
         if (log_en[s+k] !== 1'b1 || log_er[s+k] !== 1'b0 || log_d[s+k] !== b ||
             log_ss[s+k] !== (k == SLEN - 1)) e++;
      end
      if (log_en[s+SLEN] !== 1'b0) e++;
      return e;
   endfunction

   initial begin
      int c0, s, s1, s2, s3, e1, e2, off, len, nz, n, t1s, ticks, r0, r1;
      int hidx, syncs, nbad, ngap, pe, c;
      int offs[$];
      int lens[$];

      // T1 reset and idle
      repeat (3) step();
      chk("rst_txd", gmii_txd, 0);
      chk("rst_tx_en", gmii_tx_en, 0);
      chk("rst_tx_er", gmii_tx_er, 0);
      chk("rst_sync_sent", sync_sent, 0);
      chk("rst_cnt_sync", cnt_sync, 0);
      chk("rst_sync_miss", sync_miss, 0);
      chk("rst_host_ready", host_ready, 0);
      rst = 1'b0;
      t1s = cyc;
      repeat (1000) step();
      nz = 0;
      for (int k = t1s + 1; k < cyc; k++)
         if (log_en[k] !== 1'b0 || log_er[k] !== 1'b0 || log_d[k] !== 8'h00 ||
             log_ss[k] !== 1'b0 || log_rdy[k] !== 1'b0) nz++;
      chk("t1_idle_quiet", nz, 0);
      chk("t1_cnt_sync", cnt_sync, 0);

      // T2 one sync frame with a fixed t0
      local_time = 16'hA5C3;
      sync_en = 1'b1;
      c0 = cyc;
      repeat (180) step();
      sync_en = 1'b0;
      s = next_start(c0, cyc);
      chk("t2_sync_start", s, c0 + P + 2);
      chk("t2_sync_frame", sync_errs(s), 0);
      chk("t2_t0_used", (s >= 2) ? log_lt[s-2] : 16'h0, 16'hA5C3);
      nz = 0;
      for (int k = c0; k < cyc; k++) if (log_ss[k] === 1'b1) nz++;
      chk("t2_sync_sent_pulses", nz, 1);
      chk("t2_cnt_sync", cnt_sync, 1);
      repeat (20) step();

      // T3 64-byte continuous host frame
      hb.delete();
      hg.delete();
      for (int i = 0; i < 64; i++) begin
         hb.push_back(8'(i));
         hg.push_back(0);
      end
      build_exp(off, len);
      c0 = cyc;
      send_host(64, 2000);
      repeat (20) step();
      s = next_start(c0, cyc);
      chk("t3_frame", host_errs(s, off, len), 0);
      chk("t3_first_accept", acc_cyc[0], s + PRE);
      nz = 0;
      for (int k = 0; k < acc_cyc.size(); k++)
         if (log_en[acc_cyc[k]+1] !== 1'b1 || log_d[acc_cyc[k]+1] !== hb[k]) nz++;
      chk("t3_byte_latency", nz, 0);
      nz = 0;
      for (int k = s + len; k < s + len + IFG + 1; k++) if (log_en[k] !== 1'b0) nz++;
      chk("t3_ifg_idle", nz, 0);

      // T4 tick and host request meet in IDLE; a second tick lands mid host frame
      sync_en = 1'b1;
      c0 = cyc;
      repeat (P) step();
      make_frame(30, 0);
      build_exp(off, len);
      send_host(30, 2000);
      sync_en = 1'b0;
      repeat (120) step();
      s1 = next_start(c0, cyc);
      chk("t4_sync_first", s1, c0 + P + 2);
      chk("t4_sync_frame", sync_errs(s1), 0);
      e1 = s1 + SLEN - 1;
      s2 = next_start(e1 + 1, cyc);
      chk("t4_host_after_ifg", s2, e1 + IFG + 2);
      chk("t4_host_frame", host_errs(s2, off, len), 0);
      nz = 0;
      for (int k = c0 + P; k < s2 + PRE; k++) if (log_rdy[k] !== 1'b0) nz++;
      chk("t4_ready_held_low", nz, 0);
      chk("t4_first_accept", acc_cyc[0], s2 + PRE);
      e2 = s2 + len - 1;
      s3 = next_start(e2 + 1, cyc);
      chk("t4_pending_sync_after_ifg", s3, e2 + IFG + 2);
      chk("t4_pending_sync_frame", sync_errs(s3), 0);
      chk("t4_cnt_sync", cnt_sync, 3);

      // T5 two-cycle underrun in the middle of a host frame
      make_frame(40, 0);
      hg[20] = 2;
      build_exp(off, len);
      c0 = cyc;
      send_host(40, 2000);
      repeat (20) step();
      s = next_start(c0, cyc);
      chk("t5_frame", host_errs(s, off, len), 0);
      nz = 0;
      for (int k = s; k < s + len; k++)
         if (log_er[k] === 1'b1 && log_en[k] === 1'b1 && log_d[k] === 8'h00) nz++;
      chk("t5_underrun_cycles", nz, 2);

      // T6 ticks during a long host frame, then reset mid-frame
      make_frame(300, 0);
      sync_en = 1'b1;
      c0 = cyc;
      send_host(250, 2000);
      ticks = (cyc - c0) / P;
`ifdef SYNC_MISS_CNT_EN
      chk("t6_sync_miss", sync_miss, (ticks > 0) ? ticks - 1 : 0);
`else
      chk("t6_sync_miss", sync_miss, 0);
`endif
      chk("t6_mid_frame", gmii_tx_en, 1);
      rst = 1'b1;
      sync_en = 1'b0;
      step();
      chk("t6_rst_tx_en", gmii_tx_en, 0);
      chk("t6_rst_cnt_sync", cnt_sync, 0);
      chk("t6_rst_sync_miss", sync_miss, 0);
      chk("t6_rst_host_ready", host_ready, 0);
      rst = 1'b0;
      c0 = cyc;
      repeat (60) step();
      chk("t6_pending_cleared", next_start(c0, cyc), -1);

      // randomized host traffic with sync running and a moving local time
      lt_run = 1'b1;
      sync_en = 1'b1;
      r0 = cyc;
      for (int f = 0; f < 15; f++) begin
         make_frame($urandom_range(1, 45), 10);
         build_exp(off, len);
         offs.push_back(off);
         lens.push_back(len);
         send_host(hb.size(), 3000);
         n = $urandom_range(0, 30);
         repeat (n) step();
      end
      sync_en = 1'b0;
      r1 = cyc - 1;
      repeat (200) step();
      hidx = 0;
      syncs = 0;
      nbad = 0;
      ngap = 0;
      pe = -1000;
      c = r0;
      forever begin
         s = next_start(c, cyc);
         if (s < 0) break;
         if (pe > 0 && s - pe < IFG + 2) ngap++;
         if (hidx < offs.size() && host_errs(s, offs[hidx], lens[hidx]) == 0) hidx++;
         else if (sync_errs(s) == 0) syncs++;
         else nbad++;
         pe = frame_end(s);
         c = pe + 1;
      end
      ticks = (r1 - r0 + 1) / P;
      chk("rnd_host_frames", hidx, offs.size());
      chk("rnd_unknown_frames", nbad, 0);
      chk("rnd_gap_short", ngap, 0);
      chk("rnd_cnt_sync", cnt_sync, syncs);
`ifdef SYNC_MISS_CNT_EN
      chk("rnd_ticks_accounted", syncs + sync_miss, ticks);
`else
      chk("rnd_sync_miss_zero", sync_miss, 0);
      chk("rnd_syncs_le_ticks", syncs <= ticks, 1);
`endif
      chk("rnd_some_syncs", syncs > 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
